// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: scales the core's Q8.8 results by K (~0.607253) with a 16-cycle shift-add.
// Optional build macro CORDIC_GAIN_ROUND_EN selects round-half-up; otherwise results truncate toward -inf.

// state | meaning
// IDLE  | waiting for an upstream result, in_ready high
// MUL   | shift-add over the 16 bits of K_CONST, busy high
// DONE  | compensated result presented, held until out_ready
module cordic_gain_comp #(
   parameter int          WIDTH   = 16,
   parameter logic [15:0] K_CONST = 16'h9B75
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [WIDTH-1:0] in_res1,
   input  logic [WIDTH-1:0] in_res2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_mode,
   output logic [WIDTH-1:0] out_res1,
   output logic [WIDTH-1:0] out_res2,
   output logic             busy
);

   localparam int AW = 2 * WIDTH;

`ifdef CORDIC_GAIN_ROUND_EN
   localparam logic signed [AW-1:0] RND = AW'(32'h0000_8000);
`else
   localparam logic signed [AW-1:0] RND = '0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [3:0]              cnt;
   logic [WIDTH-1:0]        res1_q;
   logic [WIDTH-1:0]        res2_q;
   logic                    mode_q;
   logic signed [AW-1:0]    acc1;
   logic signed [AW-1:0]    acc2;
   logic signed [AW-1:0]    ext1;
   logic signed [AW-1:0]    ext2;
   logic signed [AW-1:0]    acc1_nxt;
   logic signed [AW-1:0]    acc2_nxt;
   logic                    accept;
   logic                    load_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      load_out  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~reset;
            accept   = in_valid & ~reset;
            if (in_valid) begin
               state_nxt = MUL;
            end
         end
         MUL: begin
            busy = 1'b1;
            // the counter wrapping out of bit 15 is the only exit
            if (cnt == 4'hF) begin
               load_out  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready  = ~reset;
               accept    = in_valid & ~reset;
               state_nxt = in_valid ? MUL : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      ext1     = {{(AW-WIDTH){res1_q[WIDTH-1]}}, res1_q};
      ext2     = {{(AW-WIDTH){res2_q[WIDTH-1]}}, res2_q};
      acc1_nxt = acc1;
      acc2_nxt = acc2;
      if (K_CONST[cnt]) begin
         acc1_nxt = acc1 + (ext1 <<< cnt);
         acc2_nxt = acc2 + (ext2 <<< cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         res1_q   <= '0;
         res2_q   <= '0;
         mode_q   <= 1'b0;
         acc1     <= '0;
         acc2     <= '0;
         out_mode <= 1'b0;
         out_res1 <= '0;
         out_res2 <= '0;
      end else begin
         if (accept) begin
            res1_q <= in_res1;
            res2_q <= in_res2;
            mode_q <= in_mode;
            acc1   <= '0;
            acc2   <= '0;
            cnt    <= '0;
         end else if (busy) begin
            acc1 <= acc1_nxt;
            acc2 <= acc2_nxt;
            cnt  <= cnt + 4'd1;
         end
         // results are taken from the final partial sum, so DONE is reached without an extra cycle
         if (load_out) begin
            out_mode <= mode_q;
            out_res1 <= WIDTH'((acc1_nxt + RND) >>> 16);
            out_res2 <= mode_q ? res2_q : WIDTH'((acc2_nxt + RND) >>> 16);
         end
      end
   end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Scoreboard bench for cordic_gain_comp: directed vectors plus a streamed random run.
// Expected rounding follows CORDIC_GAIN_ROUND_EN, as in the design.
module tb_cordic_gain_comp;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_mode = 1'b0;
   logic [15:0] in_res1 = '0;
   logic [15:0] in_res2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_mode;
   logic [15:0] out_res1;
   logic [15:0] out_res2;
   logic        busy;

   typedef struct {
      logic        mode;
      logic [15:0] r1;
      logic [15:0] r2;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   stream_on = 1'b0;
   int   last_hs = -1;
   int   acc_cyc = 0;

   cordic_gain_comp dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_res1   (in_res1),
      .in_res2   (in_res2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mode  (out_mode),
      .out_res1  (out_res1),
      .out_res2  (out_res2),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef CORDIC_GAIN_ROUND_EN
   localparam logic [15:0] E_POS1 = 16'h12AD;
   localparam logic [15:0] E_POS2 = 16'h4DBA;
   localparam logic [15:0] E_NEG1 = 16'hC1CE;
   localparam logic [15:0] E_NEG2 = 16'hB246;
`else
   localparam logic [15:0] E_POS1 = 16'h12AC;
   localparam logic [15:0] E_POS2 = 16'h4DB9;
   localparam logic [15:0] E_NEG1 = 16'hC1CD;
   localparam logic [15:0] E_NEG2 = 16'hB245;
`endif

   function automatic logic [15:0] scale(input logic [15:0] x);
      longint p;
      p = longint'($signed(x)) * 64'sd39797;
`ifdef CORDIC_GAIN_ROUND_EN
      p = p + 64'sd32768;
`endif
      return 16'(p >>> 16);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic m, input logic [15:0] r1, input logic [15:0] r2);
      exp_t e;
      e.mode = m;
      e.r1   = r1;
      e.r2   = r2;
      sb.push_back(e);
   endtask

   // Present a sample and return #1 after the edge that accepted it.
   task automatic send(input logic m, input logic [15:0] a, input logic [15:0] b, input bit keep);
      int n;
      in_valid = 1'b1;
      in_mode  = m;
      in_res1  = a;
      in_res2  = b;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk(name, 32'(out_valid), 32'd1);
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got res1=%h res2=%h with empty scoreboard", out_res1, out_res2);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_res1", 32'(out_res1), 32'(e.r1));
            chk("out_res2", 32'(out_res2), 32'(e.r2));
            chk("out_mode", 32'(out_mode), 32'(e.mode));
         end
         if (stream_on) begin
            if (last_hs >= 0) chk("stream_period", 32'(cyc - last_hs), 32'd17);
            last_hs = cyc;
         end
      end
   end

   initial begin
      #60000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] s1, s2;
      logic        sm;
      int          nb, n;
      bit          seen;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outs", {out_res1, out_res2}, 32'd0);
      chk("rst_out_mode", 32'(out_mode), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // rotation, positive, with latency and busy length
      out_ready = 1'b1;
      push(1'b0, E_POS1, E_POS2);
      send(1'b0, 16'h1EC1, 16'h7FFF, 1'b0);
      nb = 0;
      n  = 0;
      do begin
         @(negedge clk);
         if (busy) nb++;
         chk("mul_in_ready", 32'(in_ready), 32'(!busy));
         n++;
      end while (!out_valid && n < 60);
      chk("latency", 32'(cyc - acc_cyc), 32'd16);
      chk("busy_cycles", 32'(nb), 32'd16);
      @(posedge clk);
      #1;

      // negative / most-negative under backpressure
      out_ready = 1'b0;
      push(1'b0, E_NEG1, E_NEG2);
      send(1'b0, 16'h9994, 16'h8000, 1'b0);
      @(negedge clk);
      wait_valid("bp_valid_timeout");
      s1 = out_res1;
      s2 = out_res2;
      sm = out_mode;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_stable", {out_res1, out_res2}, {s1, s2});
         chk("bp_mode", 32'(out_mode), 32'(sm));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
      end

      // release together with a vectoring sample: accepted on the same edge
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mode   = 1'b1;
      in_res1   = 16'h1EC1;
      in_res2   = 16'h01DF;
      push(1'b1, E_POS1, 16'h01DF);
      @(negedge clk);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_out_valid", 32'(out_valid), 32'd0);
      wait_valid("vec_valid_timeout");
      @(posedge clk);
      #1;

      // reset in the middle of MUL; the aborted sample must never appear
      send(1'b0, 16'h1234, 16'h5678, 1'b0);
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_outs", {out_res1, out_res2}, 32'd0);
      chk("midrst_out_mode", 32'(out_mode), 32'd0);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_output", 32'(seen), 32'd0);
      @(posedge clk);
      #1;

      // streaming with in_valid and out_ready held high
      stream_on = 1'b1;
      last_hs   = -1;
      for (int i = 0; i < 20; i++) begin
         logic [15:0] a, b;
         logic        m;
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         m = 1'($urandom_range(0, 1));
         push(m, scale(a), m ? b : scale(b));
         send(m, a, b, 1'b1);
      end
      in_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      stream_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
